// File: rtl/apb_ucpd_sync_src.sv
// Source-domain end of the UCPD multi-bit toggle-handshake CDC.
// Optional one-entry pending register enabled by defining APB_UCPD_SYNC_SRC_PEND_EN.
module apb_ucpd_sync_src #(
   parameter int unsigned           WIDTH       = 8,
   parameter logic [WIDTH-1:0]      RST_VAL     = '0,
   parameter int unsigned           F_SYNC_TYPE = 2
) (
   input  logic             clk_s,
   input  logic             rst_s_n,
   input  logic             send_s,
   input  logic [WIDTH-1:0] data_s,
   input  logic             ack_d,
   output logic             req_s,
   output logic [WIDTH-1:0] data_hold,
   output logic             busy_s,
   output logic             done_s,
   output logic             ovr_s
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [F_SYNC_TYPE-1:0] ack_sync_q, ack_sync_d;
   logic [0:0]             state_q, state_d;
   logic                   req_q, req_d;
   logic [WIDTH-1:0]       data_hold_q, data_hold_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   ovr_q, ovr_d;
   logic                   ack_sync;
`ifdef APB_UCPD_SYNC_SRC_PEND_EN
   logic                   pend_vld_q, pend_vld_d;
   logic [WIDTH-1:0]       pend_data_q, pend_data_d;
`endif

   assign ack_sync = ack_sync_q[F_SYNC_TYPE-1];

   always_comb begin
      ack_sync_d  = {ack_sync_q[F_SYNC_TYPE-2:0], ack_d};
      state_d     = state_q;
      req_d       = req_q;
      data_hold_d = data_hold_q;
      done_d      = 1'b0;
      ovr_d       = 1'b0;
`ifdef APB_UCPD_SYNC_SRC_PEND_EN
      pend_vld_d  = pend_vld_q;
      pend_data_d = pend_data_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef APB_UCPD_SYNC_SRC_PEND_EN
            // Pending word launches first; a coincident send_s refills the slot.
            if (pend_vld_q) begin
               data_hold_d = pend_data_q;
               req_d       = ~req_q;
               state_d     = ST_WAIT;
               pend_vld_d  = send_s;
               if (send_s) pend_data_d = data_s;
            end else if (send_s) begin
               data_hold_d = data_s;
               req_d       = ~req_q;
               state_d     = ST_WAIT;
            end
`else
            if (send_s) begin
               data_hold_d = data_s;
               req_d       = ~req_q;
               state_d     = ST_WAIT;
            end
`endif
         end
         default: begin
            if (ack_sync == req_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
`ifdef APB_UCPD_SYNC_SRC_PEND_EN
            if (send_s) begin
               if (!pend_vld_q) begin
                  pend_vld_d  = 1'b1;
                  pend_data_d = data_s;
               end else begin
                  ovr_d = 1'b1;
               end
            end
`else
            if (send_s) ovr_d = 1'b1;
`endif
         end
      endcase
      busy_d = (state_d == ST_WAIT);
   end

   always_ff @(posedge clk_s) begin
      if (!rst_s_n) begin
         ack_sync_q  <= '0;
         state_q     <= ST_IDLE;
         req_q       <= 1'b0;
         data_hold_q <= RST_VAL;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
`ifdef APB_UCPD_SYNC_SRC_PEND_EN
         pend_vld_q  <= 1'b0;
         pend_data_q <= '0;
`endif
      end else begin
         ack_sync_q  <= ack_sync_d;
         state_q     <= state_d;
         req_q       <= req_d;
         data_hold_q <= data_hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
`ifdef APB_UCPD_SYNC_SRC_PEND_EN
         pend_vld_q  <= pend_vld_d;
         pend_data_q <= pend_data_d;
`endif
      end
   end

   assign req_s     = req_q;
   assign data_hold = data_hold_q;
   assign busy_s    = busy_q;
   assign done_s    = done_q;
   assign ovr_s     = ovr_q;

endmodule

// File: tb/tb_apb_ucpd_sync_src.sv
// Directed bench for apb_ucpd_sync_src (default build, pending register disabled).
module tb_apb_ucpd_sync_src;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       send;
   logic [7:0] data;
   logic       ack_man;
   logic       sel_man, sel_man4;

   logic       ack0, ack_r, ack4;
   logic       req0, req_r, req4;
   logic [7:0] dh0, dh_r, dh4;
   logic       busy0, busy_r, busy4;
   logic       done0, done_r, done4;
   logic       ovr0, ovr_r, ovr4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign ack0  = sel_man  ? ack_man : req0;
   assign ack_r = req_r;
   assign ack4  = sel_man4 ? ack_man : req4;

   apb_ucpd_sync_src #(.WIDTH(8), .RST_VAL(8'h00), .F_SYNC_TYPE(2)) dut (
      .clk_s(clk), .rst_s_n(rst_n), .send_s(send), .data_s(data), .ack_d(ack0),
      .req_s(req0), .data_hold(dh0), .busy_s(busy0), .done_s(done0), .ovr_s(ovr0));

   apb_ucpd_sync_src #(.WIDTH(8), .RST_VAL(8'h5A), .F_SYNC_TYPE(2)) dut_r (
      .clk_s(clk), .rst_s_n(rst_n), .send_s(send), .data_s(data), .ack_d(ack_r),
      .req_s(req_r), .data_hold(dh_r), .busy_s(busy_r), .done_s(done_r), .ovr_s(ovr_r));

   apb_ucpd_sync_src #(.WIDTH(8), .RST_VAL(8'h00), .F_SYNC_TYPE(4)) dut4 (
      .clk_s(clk), .rst_s_n(rst_n), .send_s(send), .data_s(data), .ack_d(ack4),
      .req_s(req4), .data_hold(dh4), .busy_s(busy4), .done_s(done4), .ovr_s(ovr4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      send  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; send = 1'b0; data = 8'h00;
      ack_man = 1'b0; sel_man = 1'b0; sel_man4 = 1'b0;
      #1;
      do_reset();
      chk("rst_req", req0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_ovr", ovr0, 0);
      chk("rst_dh", dh0, 8'h00);
      chk("rst_dh_rval", dh_r, 8'h5A);

      // 1: single transfer, loopback
      send = 1'b1; data = 8'hA5;
      tick(); send = 1'b0;
      chk("t1_c1_req", req0, 1);
      chk("t1_c1_dh", dh0, 8'hA5);
      chk("t1_c1_busy", busy0, 1);
      chk("t1_c1_done", done0, 0);
      tick();
      chk("t1_c2_busy", busy0, 1);
      chk("t1_c2_done", done0, 0);
      tick();
      chk("t1_c3_busy", busy0, 1);
      chk("t1_c3_done", done0, 0);
      tick();
      chk("t1_c4_done", done0, 1);
      chk("t1_c4_busy", busy0, 0);
      tick();
      chk("t1_c5_done", done0, 0);

      // 2: back-to-back
      do_reset();
      send = 1'b1; data = 8'hA5;
      tick();
      chk("t2_c1_req", req0, 1);
      tick(); tick(); tick();
      chk("t2_c4_done", done0, 1);
      data = 8'h3C;
      tick(); send = 1'b0;
      chk("t2_c5_req", req0, 0);
      chk("t2_c5_dh", dh0, 8'h3C);
      chk("t2_c5_busy", busy0, 1);
      tick(); tick();
      chk("t2_c7_done", done0, 0);
      tick();
      chk("t2_c8_done", done0, 1);

      // 3: ack never returns
      do_reset();
      sel_man = 1'b1; ack_man = 1'b0;
      send = 1'b1; data = 8'h77;
      tick(); send = 1'b0; data = 8'hEE;
      for (int i = 0; i < 8; i++) begin
         chk("t3_busy", busy0, 1);
         chk("t3_done", done0, 0);
         chk("t3_dh", dh0, 8'h77);
         tick();
      end
      sel_man = 1'b0;

      // 4: send while busy is dropped
      do_reset();
      send = 1'b1; data = 8'h11;
      tick(); send = 1'b0;
      chk("t4_c1_ovr", ovr0, 0);
      tick();
      send = 1'b1; data = 8'h22;
      tick(); send = 1'b0;
      chk("t4_c3_ovr", ovr0, 1);
      chk("t4_c3_dh", dh0, 8'h11);
      tick();
      chk("t4_c4_ovr", ovr0, 0);
      chk("t4_c4_done", done0, 1);
      chk("t4_c4_dh", dh0, 8'h11);

      // 5: reset mid-transfer, RST_VAL=5A
      do_reset();
      send = 1'b1; data = 8'h99;
      tick(); send = 1'b0;
      chk("t5_c1_dh", dh_r, 8'h99);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_req", req_r, 0);
      chk("t5_busy", busy_r, 0);
      chk("t5_dh", dh_r, 8'h5A);
      chk("t5_done", done_r, 0);
      tick();
      chk("t5_done_after", done_r, 0);
      send = 1'b1; data = 8'h44;
      tick(); send = 1'b0;
      chk("t5_new_dh", dh_r, 8'h44);
      chk("t5_new_req", req_r, 1);
      tick(); tick();
      chk("t5_new_done_early", done_r, 0);
      tick();
      chk("t5_new_done", done_r, 1);

      // 6: four-flop synchroniser, then ack toggle while idle
      do_reset();
      send = 1'b1; data = 8'h05;
      tick(); send = 1'b0;
      chk("t6_c1_busy", busy4, 1);
      tick(); tick(); tick(); tick();
      chk("t6_c5_done", done4, 0);
      chk("t6_c5_busy", busy4, 1);
      tick();
      chk("t6_c6_done", done4, 1);
      chk("t6_c6_busy", busy4, 0);
      tick();
      sel_man4 = 1'b1; ack_man = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t6_idle_req", req4, 1);
         chk("t6_idle_busy", busy4, 0);
         chk("t6_idle_done", done4, 0);
         chk("t6_idle_ovr", ovr4, 0);
         chk("t6_idle_dh", dh4, 8'h05);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
